// File: rtl/simon_key_sched.sv
// simon_key_sched: key-side end of an iterative SIMON-128/128 round core.
//
// Expands a 128-bit master key into 68 64-bit round keys and holds them in
// local storage. It then streams one key per cycle, in forward order for
// encryption or reverse order for decryption. It also drives the round
// core's reset, so the core's round counter stays aligned with the stream.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   start     request a new schedule (sampled only while ready=1)
//   encNdec   1 = encrypt (forward keys), 0 = decrypt (reverse keys)
//   key_in    master key, key_in[63:0] = k0, key_in[127:64] = k1
//   ready     idle, start will be accepted
//   core_rst  reset for the round core (high = core loads its input)
//   rk        round key for the core
//   rk_valid  rk is a live round key this cycle
//   ks_done   one-cycle pulse, coincident with the core's done
//
// Optional build macro SIMON_KS_ZEROIZE_EN:
//   - Clears all storage and the expansion shift pair in the DONE cycle
//     and on rst.
//   - Forces rk to 0 whenever rk_valid=0.
//   Timing is the same with or without the macro.
module simon_key_sched #(
   parameter int ROUNDS = 68,
   parameter int CW     = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         encNdec,
   input  logic [127:0] key_in,
   output logic         ready,
   output logic         core_rst,
   output logic [63:0]  rk,
   output logic         rk_valid,
   output logic         ks_done
);

   // z2 sequence, index 0 is the leftmost (MSB) bit. Padded to 64 bits so
   // that any 6-bit position is in range.
   localparam logic [61:0]    Z2      = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [63:0]    Z2W     = {2'b00, Z2};
   localparam logic [63:0]    C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [CW-1:0]  LAST    = CW'(ROUNDS - 1);

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   typedef enum logic [1:0] {IDLE, EXPAND, STREAM, DONE} state_t;

   state_t                   state, state_nxt;
   logic [CW-1:0]            cnt, rd_idx, z_i;
   logic [5:0]               z_pos;
   logic                     enc;
   logic [ROUNDS-1:0][63:0]  mem;
   logic [63:0]              ka, kb, k_new, rk_rd, rk_hold;

   // The next key is k[cnt], built from k[cnt-2] (ka) and k[cnt-1] (kb).
   // Its z bit is index (cnt-2) mod 62, counted from the MSB of Z2.
   always_comb begin
      z_i = cnt - CW'(2);
      if (z_i >= CW'(62)) z_i = z_i - CW'(62);
      z_pos = 6'(CW'(61) - z_i);
      k_new = C_CONST ^ {63'd0, Z2W[z_pos]} ^ ka ^ ror64(kb, 3) ^ ror64(kb, 4);
   end

   // Combinational read: forward index when encrypting, mirrored when decrypting.
   always_comb begin
      rd_idx = enc ? cnt : (LAST - cnt);
      rk_rd  = mem[rd_idx];
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      core_rst  = 1'b1;
      rk_valid  = 1'b0;
      ks_done   = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = EXPAND;
         end
         EXPAND: begin
            if (cnt == LAST) state_nxt = STREAM;
         end
         STREAM: begin
            core_rst = 1'b0;
            rk_valid = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         default: begin
            ks_done   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Control: state, round/address counter and the held rk value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rk_hold <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE:    if (start) cnt <= CW'(2);
            EXPAND:  cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            STREAM: begin
               rk_hold <= rk_rd;
               cnt     <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
            default: cnt <= '0;
         endcase
      end
   end

   // Key storage and expansion shift pair. The two operands of each step
   // are carried in ka/kb, so the array needs only one write per cycle.
   always_ff @(posedge clk) begin
`ifdef SIMON_KS_ZEROIZE_EN
      if (rst || state == DONE) begin
         mem <= '0;
         ka  <= '0;
         kb  <= '0;
      end else
`endif
      if (state == IDLE && start) begin
         mem[0] <= key_in[63:0];
         mem[1] <= key_in[127:64];
         ka     <= key_in[63:0];
         kb     <= key_in[127:64];
         enc    <= encNdec;
      end else if (state == EXPAND) begin
         mem[cnt] <= k_new;
         ka       <= kb;
         kb       <= k_new;
      end
   end

`ifdef SIMON_KS_ZEROIZE_EN
   assign rk = rk_valid ? rk_rd : 64'd0;
`else
   assign rk = (state == STREAM) ? rk_rd : rk_hold;
`endif

endmodule

// File: tb/tb_simon_key_sched.sv
module tb_simon_key_sched;

   logic         clk = 1'b0;
   logic         rst, start, encNdec;
   logic [127:0] key_in;
   logic         ready, core_rst, rk_valid, ks_done;
   logic [63:0]  rk;

   always #5 clk = ~clk;

   simon_key_sched dut (
      .clk(clk), .rst(rst), .start(start), .encNdec(encNdec), .key_in(key_in),
      .ready(ready), .core_rst(core_rst), .rk(rk), .rk_valid(rk_valid), .ks_done(ks_done)
   );

   localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] PT  = 128'h63736564207372656c6c657661727420;
   localparam logic [127:0] CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

   string Z2S = "10101111011100000011010010011000101000010001111110010110110011";

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int runs_done = 0;
   bit chk_en = 0;

   // ---------------- behavioural model ----------------
   logic [63:0]  sched   [68];
   logic [63:0]  mem_exp [68];
   bit           act = 0;
   int           m = 0;
   bit           m_enc = 0;
   logic [63:0]  last_rk = '0;
   logic [127:0] data_in = '0;
   logic [127:0] exp_ct = '0;
   bit           core_enc = 0;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   function automatic logic [63:0] fr(input logic [63:0] x);
      return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
   endfunction

   function automatic void expand(input logic [127:0] key);
      logic [63:0] t;
      sched[0] = key[63:0];
      sched[1] = key[127:64];
      for (int i = 0; i < 66; i++) begin
         t = rotr(sched[i+1], 3);
         t = t ^ rotr(t, 1);
         sched[i+2] = 64'hFFFF_FFFF_FFFF_FFFC ^ 64'(Z2S[i % 62] == "1") ^ sched[i] ^ t;
      end
   endfunction

   function automatic logic [127:0] sw_cipher(input logic [127:0] blk, input bit e);
      logic [63:0] x, y, k, t;
      x = blk[127:64];
      y = blk[63:0];
      for (int r = 0; r < 68; r++) begin
         k = e ? sched[r] : sched[67 - r];
         if (e) begin t = x; x = y ^ fr(x) ^ k; y = t; end
         else   begin t = y; y = x ^ fr(y) ^ k; x = t; end
      end
      return {x, y};
   endfunction

   function automatic logic [63:0] key_at(input int mm);
      return m_enc ? sched[mm - 66] : sched[133 - mm];
   endfunction

   // m = clock edges since the accepted start edge:
   // 0..65 expand, 66..133 stream round m-66, 134 done.
   always @(posedge clk) begin
      if (rst) begin
         act = 0;
         last_rk = '0;
`ifdef SIMON_KS_ZEROIZE_EN
         for (int i = 0; i < 68; i++) mem_exp[i] = '0;
`endif
      end else if (act) begin
         if (m >= 66 && m <= 133) last_rk = key_at(m);
         m++;
         if (m == 135) begin
            act = 0;
`ifdef SIMON_KS_ZEROIZE_EN
            for (int i = 0; i < 68; i++) mem_exp[i] = '0;
`endif
         end
      end else if (start) begin
         act = 1;
         m = 0;
         m_enc = encNdec;
         expand(key_in);
         for (int i = 0; i < 68; i++) mem_exp[i] = sched[i];
         exp_ct = sw_cipher(data_in, encNdec);
      end
   end

   // ---------------- behavioural round core fed by the DUT ----------------
   logic [63:0] cx, cy, rk_s, ctmp;
   logic        crst_s;

   always @(negedge clk) begin
      crst_s = core_rst;
      rk_s   = rk;
   end

   always @(posedge clk) begin
      if (crst_s === 1'b1) begin
         cx = data_in[127:64];
         cy = data_in[63:0];
      end else if (core_enc) begin
         ctmp = cx; cx = cy ^ fr(cx) ^ rk_s; cy = ctmp;
      end else begin
         ctmp = cy; cy = cx ^ fr(cy) ^ rk_s; cx = ctmp;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, a, e);
      end
   endtask

   task automatic compare_cycle();
      bit          ev;
      logic [63:0] erk;
      ev = act && m >= 66 && m <= 133;
      chk("ready",    128'(ready),    128'(!act));
      chk("core_rst", 128'(core_rst), 128'(!ev));
      chk("rk_valid", 128'(rk_valid), 128'(ev));
      chk("ks_done",  128'(ks_done),  128'(act && m == 134));
      if (ev) erk = key_at(m);
`ifdef SIMON_KS_ZEROIZE_EN
      else erk = '0;
`else
      else erk = last_rk;
`endif
      chk("rk", 128'(rk), 128'(erk));
      if (ks_done === 1'b1) done_seen++;
      if (act && m == 134) chk("dataout", {cx, cy}, exp_ct);
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_m(input int target);
      for (int i = 0; i < 400; i++) begin
         if (act && m == target) return;
         tick(1);
      end
      chk("wait_timeout", 128'(m), 128'(target));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         if (!act) return;
         tick(1);
      end
      chk("idle_timeout", 128'(act), 128'(0));
   endtask

   task automatic run(input logic [127:0] key, input logic [127:0] din, input bit e,
                      input bit glitch, input int abort_at);
      key_in = key; encNdec = e; data_in = din; core_enc = e; start = 1'b1;
      tick(1);
      start = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      encNdec = 1'($urandom);
      if (glitch) begin wait_m(10); start = 1'b1; tick(1); start = 1'b0; end
      if (abort_at >= 0) begin
         wait_m(abort_at);
         rst = 1'b1; tick(1); rst = 1'b0;
         tick(2);
         chk("no_ks_done", 128'(done_seen), 128'(runs_done));
      end else begin
         if (glitch) begin wait_m(134); start = 1'b1; tick(1); start = 1'b0; end
         wait_idle();
         runs_done++;
         chk("ks_done_count", 128'(done_seen), 128'(runs_done));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; encNdec = 1'b1; key_in = '0;
      fork
         forever begin
            @(negedge clk);
            if (chk_en) compare_cycle();
         end
      join_none
      tick(2);
      rst = 1'b0;
      chk_en = 1;
      tick(2);

      // known-answer encrypt, with ignored starts in EXPAND and DONE
      run(KEY, PT, 1'b1, 1'b1, -1);
      chk("model_k0", 128'(sched[0]), 128'(64'h0706050403020100));
      chk("model_k1", 128'(sched[1]), 128'(64'h0f0e0d0c0b0a0908));
      chk("model_ct", exp_ct, CT);

      // known-answer decrypt
      run(KEY, CT, 1'b0, 1'b0, -1);
      chk("model_pt", exp_ct, PT);
      tick(1);
      for (int i = 0; i < 68; i++) chk($sformatf("mem%0d", i), 128'(dut.mem[i]), 128'(mem_exp[i]));

      // reset during STREAM round 30, then a fresh encrypt
      run({$urandom, $urandom, $urandom, $urandom}, PT, 1'b1, 1'b0, 96);
      run(KEY, PT, 1'b1, 1'b0, -1);

      // randomized schedules, directions, glitches and aborts
      for (int n = 0; n < 8; n++) begin
         bit g;
         int ab;
         g  = 1'($urandom);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 134)) : -1;
         run({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), g, ab);
      end

      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
